// File: rtl/seven_seg_scan_controller_pkg.sv
// Shared definitions for the 4-digit 7-segment scan controller:
// slot state encoding, blank/off constants and hex segment patterns.
package seven_seg_scan_controller_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_e;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    // Active-low segment patterns, bit order gfedcba.
    localparam logic [6:0] SEG_HEX_0 = 7'b1000000;
    localparam logic [6:0] SEG_HEX_1 = 7'b1111001;
    localparam logic [6:0] SEG_HEX_2 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_3 = 7'b0110000;
    localparam logic [6:0] SEG_HEX_4 = 7'b0011001;
    localparam logic [6:0] SEG_HEX_5 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_6 = 7'b0000010;
    localparam logic [6:0] SEG_HEX_7 = 7'b1111000;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0010000;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b0000011;
    localparam logic [6:0] SEG_HEX_C = 7'b1000110;
    localparam logic [6:0] SEG_HEX_D = 7'b0100001;
    localparam logic [6:0] SEG_HEX_E = 7'b0000110;
    localparam logic [6:0] SEG_HEX_F = 7'b0001110;

endpackage

// File: rtl/seven_seg_scan_controller_hex_to_7seg.sv
// Combinational nibble to active-low gfedcba segment decoder.
module hex_to_7seg
    import seven_seg_scan_controller_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (nibble)
            4'h0: segments = SEG_HEX_0;
            4'h1: segments = SEG_HEX_1;
            4'h2: segments = SEG_HEX_2;
            4'h3: segments = SEG_HEX_3;
            4'h4: segments = SEG_HEX_4;
            4'h5: segments = SEG_HEX_5;
            4'h6: segments = SEG_HEX_6;
            4'h7: segments = SEG_HEX_7;
            4'h8: segments = SEG_HEX_8;
            4'h9: segments = SEG_HEX_9;
            4'hA: segments = SEG_HEX_A;
            4'hB: segments = SEG_HEX_B;
            4'hC: segments = SEG_HEX_C;
            4'hD: segments = SEG_HEX_D;
            4'hE: segments = SEG_HEX_E;
            4'hF: segments = SEG_HEX_F;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_controller.sv
// Frame-synchronous 4-digit display scanner with anti-ghost blanking,
// PWM brightness and a double-buffered display word with load handshake.
module seven_seg_scan_controller
    import seven_seg_scan_controller_pkg::*;
#(
    parameter int Divider      = 10000,
    parameter int BlankCycles  = 500,
    parameter int NumberOfBits = 14
) (
    input  logic        CLOCK,
    input  logic        Reset,
    input  logic        Load,
    input  logic [15:0] DataIn,
    input  logic [3:0]  DigitEnable,
    input  logic [3:0]  Brightness,
    output logic [3:0]  Transistors,
    output logic [6:0]  Segments,
    output logic [1:0]  Digit,
    output logic        LoadAck
);

    localparam logic [NumberOfBits-1:0] LastCount = NumberOfBits'(Divider - 1);
    localparam logic [NumberOfBits-1:0] LastBlank = NumberOfBits'(BlankCycles - 1);

    scan_state_e             state_q, state_d;
    logic [NumberOfBits-1:0] count_q, count_d;
    logic [1:0]              digit_q, digit_d;
    logic [3:0]              phase_q, phase_d;
    logic [15:0]             shadow_q, shadow_d;
    logic [15:0]             active_q, active_d;
    logic                    pending_q, pending_d;
    logic [3:0]              an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic [1:0]              digit_out_q, digit_out_d;
    logic                    ack_q, ack_d;

    logic       slot_end;
    logic       frame_end;
    logic [3:0] cur_nibble;
    logic [6:0] cur_segments;

    assign slot_end   = (count_q == LastCount);
    assign frame_end  = slot_end && (digit_q == 2'd3);
    assign cur_nibble = active_q[{digit_q, 2'b00} +: 4];

    hex_to_7seg u_hex_to_7seg (
        .nibble   (cur_nibble),
        .segments (cur_segments)
    );

    always_comb begin
        count_d = count_q + NumberOfBits'(1);
        digit_d = digit_q;
        if (slot_end) begin
            count_d = '0;
            digit_d = digit_q + 2'd1;
        end
    end

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            state_q <= BLANK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BLANK:   if (count_q == LastBlank) state_d = DRIVE;
            DRIVE:   if (slot_end) state_d = BLANK;
            default: state_d = BLANK;
        endcase
    end

    // Phase restarts from zero on every DRIVE entry so each digit sees the same duty pattern.
    always_comb begin
        an_d    = AN_OFF;
        seg_d   = SEG_BLANK;
        phase_d = '0;
        if (state_q == DRIVE) begin
            seg_d   = cur_segments;
            phase_d = phase_q + 4'd1;
            if ((phase_q < Brightness) && DigitEnable[digit_q]) begin
                an_d[digit_q] = 1'b0;
            end
        end
        digit_out_d = digit_q;
    end

    // A Load coinciding with the frame edge still transfers the old shadow; the new word waits a frame.
    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        ack_d     = frame_end && pending_q;
        if (ack_d) begin
            active_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (Load) begin
            shadow_d  = DataIn;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            count_q     <= '0;
            digit_q     <= 2'd0;
            phase_q     <= 4'd0;
            shadow_q    <= 16'h0000;
            active_q    <= 16'h0000;
            pending_q   <= 1'b0;
            an_q        <= AN_OFF;
            seg_q       <= SEG_BLANK;
            digit_out_q <= 2'd0;
            ack_q       <= 1'b0;
        end else begin
            count_q     <= count_d;
            digit_q     <= digit_d;
            phase_q     <= phase_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            an_q        <= an_d;
            seg_q       <= seg_d;
            digit_out_q <= digit_out_d;
            ack_q       <= ack_d;
        end
    end

    assign Transistors = an_q;
    assign Segments    = seg_q;
    assign Digit       = digit_out_q;
    assign LoadAck     = ack_q;

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Self-checking bench for seven_seg_scan_controller against a cycle-index reference model.
module tb_seven_seg_scan_controller;

    localparam int DIV   = 20;
    localparam int BLK   = 4;
    localparam int NB    = 5;
    localparam int FRAME = 4 * DIV;

    localparam logic [6:0] SEG_OFF = 7'b1111111;
    localparam logic [6:0] HEX_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
    localparam logic [6:0] WANT_1234 [4] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    logic        CLOCK = 1'b0;
    logic        Reset = 1'b1;
    logic        Load = 1'b0;
    logic [15:0] DataIn = 16'h0000;
    logic [3:0]  DigitEnable = 4'hF;
    logic [3:0]  Brightness = 4'hF;
    logic [3:0]  Transistors;
    logic [6:0]  Segments;
    logic [1:0]  Digit;
    logic        LoadAck;

    int errors = 0;
    int checks = 0;

    int          m_cycle = 0;
    int          m_cnt, m_slot, m_phase;
    logic [15:0] m_active = 16'h0, m_shadow = 16'h0;
    logic        m_pending = 1'b0;
    logic [3:0]  exp_an = 4'hF;
    logic [6:0]  exp_seg = 7'h7F;
    logic [1:0]  exp_dig = 2'd0;
    logic        exp_ack = 1'b0;

    seven_seg_scan_controller #(
        .Divider      (DIV),
        .BlankCycles  (BLK),
        .NumberOfBits (NB)
    ) dut (
        .CLOCK       (CLOCK),
        .Reset       (Reset),
        .Load        (Load),
        .DataIn      (DataIn),
        .DigitEnable (DigitEnable),
        .Brightness  (Brightness),
        .Transistors (Transistors),
        .Segments    (Segments),
        .Digit       (Digit),
        .LoadAck     (LoadAck)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference model: m_cycle is the internal cycle index since reset; outputs show the cycle just finished.
    always @(posedge CLOCK or negedge Reset) begin
        if (!Reset) begin
            m_cycle   = 0;
            m_active  = 16'h0;
            m_shadow  = 16'h0;
            m_pending = 1'b0;
            exp_an    = 4'hF;
            exp_seg   = SEG_OFF;
            exp_dig   = 2'd0;
            exp_ack   = 1'b0;
        end else begin
            m_cnt   = m_cycle % DIV;
            m_slot  = (m_cycle / DIV) % 4;
            exp_dig = 2'(m_slot);
            exp_an  = 4'hF;
            exp_seg = SEG_OFF;
            if (m_cnt >= BLK) begin
                exp_seg = HEX_TAB[m_active[4*m_slot +: 4]];
                m_phase = (m_cnt - BLK) % 16;
                if (m_phase < int'(Brightness) && DigitEnable[m_slot]) exp_an[m_slot] = 1'b0;
            end
            exp_ack = ((m_cycle % FRAME) == FRAME - 1) && m_pending;
            if (exp_ack) begin
                m_active  = m_shadow;
                m_pending = 1'b0;
            end
            if (Load) begin
                m_shadow  = DataIn;
                m_pending = 1'b1;
            end
            m_cycle++;
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #1;
        Reset = 1'b0;
        #1;
        checks++;
        if ({Transistors, Segments, Digit, LoadAck} !== {4'b1111, 7'b1111111, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_async: got an=%b seg=%b dig=%0d ack=%b, want 1111 1111111 0 0", Transistors, Segments, Digit, LoadAck);
        end
        repeat (3) tick();
        checks++;
        if ({Transistors, Segments, Digit, LoadAck} !== {4'b1111, 7'b1111111, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_hold: got an=%b seg=%b dig=%0d ack=%b, want 1111 1111111 0 0", Transistors, Segments, Digit, LoadAck);
        end
        @(negedge CLOCK);
        Reset = 1'b1;
        for (int i = 1; i <= 5 * DIV; i++) begin
            tick();
            checks++;
            if ({Transistors, Segments, Digit, LoadAck} !== {exp_an, exp_seg, exp_dig, exp_ack}) begin
                errors++;
                $display("[TB] FAIL reset_model t=%0t: got an=%b seg=%b dig=%0d ack=%b, want an=%b seg=%b dig=%0d ack=%b", $time, Transistors, Segments, Digit, LoadAck, exp_an, exp_seg, exp_dig, exp_ack);
            end
            checks++;
            if (Digit !== 2'((i - 1) / DIV)) begin
                errors++;
                $display("[TB] FAIL reset_digit_seq sample %0d: got %0d want %0d", i, Digit, 2'((i - 1) / DIV));
            end
        end
    endtask

    task automatic test_load();
        int ack_at = -1;
        int acks = 0, bad = 0, blanks0 = 0, lit0 = 0;
        Brightness = 4'd15;
        DigitEnable = 4'hF;
        DataIn = 16'h1234;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 2 * FRAME && ack_at < 0; i++) begin
            tick();
            checks++;
            if ({Transistors, Segments, Digit, LoadAck} !== {exp_an, exp_seg, exp_dig, exp_ack}) begin
                errors++;
                $display("[TB] FAIL load_model t=%0t: got an=%b seg=%b dig=%0d ack=%b, want an=%b seg=%b dig=%0d ack=%b", $time, Transistors, Segments, Digit, LoadAck, exp_an, exp_seg, exp_dig, exp_ack);
            end
            if (LoadAck === 1'b1) begin
                ack_at = i;
                acks = 1;
            end
        end
        checks++;
        if (ack_at < 0) begin
            errors++;
            $display("[TB] FAIL load_ack_timeout: got no LoadAck within %0d cycles, want one", 2 * FRAME);
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if ({Transistors, Segments, Digit, LoadAck} !== {exp_an, exp_seg, exp_dig, exp_ack}) begin
                errors++;
                $display("[TB] FAIL load_model t=%0t: got an=%b seg=%b dig=%0d ack=%b, want an=%b seg=%b dig=%0d ack=%b", $time, Transistors, Segments, Digit, LoadAck, exp_an, exp_seg, exp_dig, exp_ack);
            end
            if (LoadAck === 1'b1) acks++;
            if (Segments !== SEG_OFF && Segments !== WANT_1234[Digit]) bad++;
            if (Digit === 2'd0 && Segments === SEG_OFF) blanks0++;
            if (Digit === 2'd0 && Transistors === 4'b1110) lit0++;
        end
        checks++;
        if (acks !== 1) begin errors++; $display("[TB] FAIL load_ack_count: got %0d want 1", acks); end
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL load_pattern_1234: got %0d wrong samples want 0", bad); end
        checks++;
        if (blanks0 !== BLK) begin errors++; $display("[TB] FAIL load_blank_digit0: got %0d want %0d", blanks0, BLK); end
        checks++;
        if (lit0 !== 15) begin errors++; $display("[TB] FAIL load_lit_digit0: got %0d want 15", lit0); end
    endtask

    task automatic test_brightness();
        int lit = 0, lit_dark = 0, lit2 = 0, steps = 0;
        logic [1:0] prev;
        for (int i = 0; i < 3 * FRAME; i++) begin
            Brightness = 4'($urandom);
            DigitEnable = 4'($urandom);
            tick();
            checks++;
            if ({Transistors, Segments, Digit, LoadAck} !== {exp_an, exp_seg, exp_dig, exp_ack}) begin
                errors++;
                $display("[TB] FAIL bright_random t=%0t: got an=%b seg=%b dig=%0d ack=%b, want an=%b seg=%b dig=%0d ack=%b", $time, Transistors, Segments, Digit, LoadAck, exp_an, exp_seg, exp_dig, exp_ack);
            end
        end
        Brightness = 4'd8;
        DigitEnable = 4'hF;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (Transistors !== 4'b1111) lit++;
        end
        checks++;
        if (lit !== 32) begin errors++; $display("[TB] FAIL bright_8_lit: got %0d lit cycles per frame want 32", lit); end
        Brightness = 4'd0;
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (Transistors !== 4'b1111) lit_dark++;
        end
        checks++;
        if (lit_dark !== 0) begin errors++; $display("[TB] FAIL bright_0_dark: got %0d lit cycles want 0", lit_dark); end
        Brightness = 4'd15;
        DigitEnable = 4'b1011;
        prev = Digit;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            checks++;
            if ({Transistors, Segments, Digit, LoadAck} !== {exp_an, exp_seg, exp_dig, exp_ack}) begin
                errors++;
                $display("[TB] FAIL bright_enable t=%0t: got an=%b seg=%b dig=%0d ack=%b, want an=%b seg=%b dig=%0d ack=%b", $time, Transistors, Segments, Digit, LoadAck, exp_an, exp_seg, exp_dig, exp_ack);
            end
            if (Transistors[2] === 1'b0) lit2++;
            if (Digit !== prev) steps++;
            prev = Digit;
        end
        checks++;
        if (lit2 !== 0) begin errors++; $display("[TB] FAIL enable_digit2_dark: got %0d lit cycles want 0", lit2); end
        checks++;
        if (steps !== 8) begin errors++; $display("[TB] FAIL enable_slot_timing: got %0d digit steps want 8", steps); end
        DigitEnable = 4'hF;
    endtask

    task automatic test_back_to_back();
        int acks = 0, bad = 0, seen = 0;
        for (int i = 0; i < FRAME && (m_cycle % FRAME) != 5; i++) tick();
        DataIn = 16'hAAAA;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        repeat (10) tick();
        DataIn = 16'h5555;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int i = 0; i < 2 * FRAME && seen == 0; i++) begin
            tick();
            checks++;
            if ({Transistors, Segments, Digit, LoadAck} !== {exp_an, exp_seg, exp_dig, exp_ack}) begin
                errors++;
                $display("[TB] FAIL b2b_model t=%0t: got an=%b seg=%b dig=%0d ack=%b, want an=%b seg=%b dig=%0d ack=%b", $time, Transistors, Segments, Digit, LoadAck, exp_an, exp_seg, exp_dig, exp_ack);
            end
            if (LoadAck === 1'b1) begin seen = 1; acks++; end
        end
        checks++;
        if (seen == 0) begin errors++; $display("[TB] FAIL b2b_ack_timeout: got no LoadAck want one"); end
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            if (LoadAck === 1'b1) acks++;
            if (i < FRAME && Segments !== SEG_OFF && Segments !== 7'b0010010) bad++;
        end
        checks++;
        if (acks !== 1) begin errors++; $display("[TB] FAIL b2b_ack_count: got %0d want 1", acks); end
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL b2b_pattern_5555: got %0d wrong samples want 0", bad); end
    endtask

    task automatic test_boundary_load();
        int acks1 = 0, acks2 = 0, bad1 = 0, bad2 = 0, ack_pos = -1;
        for (int i = 0; i < FRAME && (m_cycle % FRAME) != 10; i++) tick();
        DataIn = 16'h1111;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int i = 0; i < FRAME && (m_cycle % FRAME) != FRAME - 1; i++) tick();
        DataIn = 16'hFFFF;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        checks++;
        if (LoadAck !== 1'b1) begin errors++; $display("[TB] FAIL boundary_first_ack: got %b want 1", LoadAck); end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            checks++;
            if ({Transistors, Segments, Digit, LoadAck} !== {exp_an, exp_seg, exp_dig, exp_ack}) begin
                errors++;
                $display("[TB] FAIL boundary_model t=%0t: got an=%b seg=%b dig=%0d ack=%b, want an=%b seg=%b dig=%0d ack=%b", $time, Transistors, Segments, Digit, LoadAck, exp_an, exp_seg, exp_dig, exp_ack);
            end
            if (LoadAck === 1'b1) begin acks1++; ack_pos = i; end
            if (Segments !== SEG_OFF && Segments !== 7'b1111001) bad1++;
        end
        for (int i = 0; i < FRAME; i++) begin
            tick();
            if (LoadAck === 1'b1) acks2++;
            if (Segments !== SEG_OFF && Segments !== 7'b0001110) bad2++;
        end
        checks++;
        if (acks1 !== 1 || ack_pos !== FRAME - 1) begin
            errors++;
            $display("[TB] FAIL boundary_second_ack: got %0d acks at %0d want 1 at %0d", acks1, ack_pos, FRAME - 1);
        end
        checks++;
        if (acks2 !== 0) begin errors++; $display("[TB] FAIL boundary_extra_ack: got %0d want 0", acks2); end
        checks++;
        if (bad1 !== 0) begin errors++; $display("[TB] FAIL boundary_pattern_1111: got %0d wrong samples want 0", bad1); end
        checks++;
        if (bad2 !== 0) begin errors++; $display("[TB] FAIL boundary_pattern_FFFF: got %0d wrong samples want 0", bad2); end
    endtask

    task automatic test_reset_mid();
        int acks = 0, bad = 0;
        Brightness = 4'd15;
        DigitEnable = 4'hF;
        for (int i = 0; i < FRAME && (m_cycle % FRAME) != 2; i++) tick();
        DataIn = 16'hBEEF;
        Load = 1'b1;
        tick();
        Load = 1'b0;
        for (int i = 0; i < FRAME && (m_cycle % FRAME) != 2 * DIV + 10; i++) tick();
        checks++;
        if (Digit !== 2'd2 || Transistors !== 4'b1011) begin
            errors++;
            $display("[TB] FAIL midreset_precondition: got dig=%0d an=%b want dig=2 an=1011", Digit, Transistors);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({Transistors, Segments, Digit, LoadAck} !== {4'b1111, 7'b1111111, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_async: got an=%b seg=%b dig=%0d ack=%b, want 1111 1111111 0 0", Transistors, Segments, Digit, LoadAck);
        end
        @(negedge CLOCK);
        Reset = 1'b1;
        for (int i = 0; i < 2 * FRAME + 10; i++) begin
            tick();
            checks++;
            if ({Transistors, Segments, Digit, LoadAck} !== {exp_an, exp_seg, exp_dig, exp_ack}) begin
                errors++;
                $display("[TB] FAIL midreset_model t=%0t: got an=%b seg=%b dig=%0d ack=%b, want an=%b seg=%b dig=%0d ack=%b", $time, Transistors, Segments, Digit, LoadAck, exp_an, exp_seg, exp_dig, exp_ack);
            end
            if (LoadAck === 1'b1) acks++;
            if (Segments !== SEG_OFF && Segments !== 7'b1000000) bad++;
        end
        checks++;
        if (acks !== 0) begin errors++; $display("[TB] FAIL midreset_stale_ack: got %0d want 0", acks); end
        checks++;
        if (bad !== 0) begin errors++; $display("[TB] FAIL midreset_pattern_0000: got %0d wrong samples want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_brightness();
        test_back_to_back();
        test_boundary_load();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion by t=%0t, want completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
